wb_stage_ctrl: RTL and testbench
================================

# wb_stage_ctrl

Parametrised, registered write-back stage for the pipelined processor. It accepts one retiring instruction per cycle from the memory stage through a valid/ready handshake and decodes the opcode to select the write-back source and the register-file write enable. Loads whose read data is not yet available are held until the data arrives, stalling upstream. It drives the register-file write port and a retired-instruction counter.

## Interface
- DATA_W, 20: datapath width (ALU result, register data, memory data)
- INSTR_W, 20: instruction width; opcode = instruction[INSTR_W-1 -: 4]
- REG_ADDR_W, 4: register address width
- R0_HARDWIRED, 0: 1 = writes to register address 0 are suppressed
- COUNT_W, 16: retired-instruction counter width

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept; combinational from state
- instruction  in  INSTR_W  retiring instruction
- alu_result  in  DATA_W  ALU result
- rf_data1  in  DATA_W  register operand 1
- address  in  REG_ADDR_W  destination register
- mem_rdata  in  DATA_W  load data
- mem_rvalid  in  1  mem_rdata valid this cycle
- wb_enable  out  1  register-file write strobe, one cycle per write
- wb_address  out  REG_ADDR_W  write address
- wb_data  out  DATA_W  write data
- busy  out  1  high in WAIT_MEM
- retired_count  out  COUNT_W  retired instructions, wraps

## Operation
- Opcode decode (4 bits):
  - 1100 store: no write.
  - 1011 conditional move: write rf_data1 only if alu_result == 0; otherwise no write.
  - 1111, 1101 load: write mem_rdata.
  - 1110 move: write rf_data1.
  - All other opcodes: write alu_result.
- R0_HARDWIRED=1 and address == 0: write enable forced 0; the instruction still retires.
- Accept = in_valid & in_ready at a rising edge.
- FSM has two states, IDLE and WAIT_MEM.
  - IDLE: in_ready=1.
  - Non-load accepted: retire at that edge.
  - Load accepted with mem_rvalid=1 in the same cycle: capture mem_rdata and retire at that edge.
  - Load accepted with mem_rvalid=0: latch address, go to WAIT_MEM.
  - WAIT_MEM: in_ready=0, busy=1. The first edge with mem_rvalid=1 captures mem_rdata, retires, and returns to IDLE. There is no timeout.
- Retire:
  - Register wb_enable per the decode.
  - Load wb_address and wb_data with the selected values even when the write is suppressed.
  - retired_count += 1, modulo 2^COUNT_W.
- Cycles with no retire: wb_enable=0; wb_address and wb_data hold their last values.
- mem_rvalid in IDLE is ignored unless a load is accepted in the same cycle.

## Timing
- Reset (reset=0 at an edge): state=IDLE, wb_enable=0, wb_address=0, wb_data=0, busy=0, retired_count=0. in_ready=0 combinationally while reset=0.
- Reset during WAIT_MEM abandons the pending load (no write). A mem_rvalid arriving later is ignored.
- Latency: accept at edge N → wb_enable/wb_address/wb_data valid after edge N. Write occurs at the register file on edge N+1.
- Throughput: 1 instruction/cycle for non-loads and for loads with same-cycle mem_rvalid.
- A load waiting k cycles for data blocks input for k cycles. in_ready returns high in the cycle after the load retires.
- Back-to-back retires give consecutive wb_enable pulses, with no bubble inserted.

## Test plan
- Reset check: hold reset=0 two cycles with in_valid=1, opcode 0000 → all outputs 0, in_ready=0, retired_count=0. Release and accept opcode 0000, alu_result=0x12345, address=3 → next cycle wb_enable=1, wb_address=3, wb_data=0x12345, retired_count=1.
- Conditional move: opcode 1011, rf_data1=0xABCDE.
  - alu_result=0 → write 0xABCDE.
  - alu_result=1 → wb_enable=0, retired_count still increments.
- Store and R0: opcode 1100 → wb_enable=0. With R0_HARDWIRED=1, opcode 0001 to address 0 → wb_enable=0; same with R0_HARDWIRED=0 → wb_enable=1.
- Load with wait: opcode 1111, mem_rvalid delayed 3 cycles with mem_rdata=0x0F0F0 → busy=1 and in_ready=0 for 3 cycles, then wb_enable=1, wb_data=0x0F0F0. A following in_valid is held and accepted afterwards.
- Reset mid-wait: load accepted, reset=0 during WAIT_MEM, then mem_rvalid=1 → no wb_enable, state IDLE, retired_count=0.
- Stream and wrap: COUNT_W=4, 17 back-to-back ALU instructions → 17 consecutive wb_enable pulses, retired_count=1.

Source files
------------

// File: rtl/wb_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_ctrl
// Description : Registered write-back stage. Accepts one retiring instruction
//               per cycle over a valid/ready handshake, decodes the opcode to
//               choose the write-back source and register-file write enable,
//               holds loads until their read data arrives, and counts retired
//               instructions.
// Ports       : clock, reset (sync, active-low)
//               in_valid/in_ready      - handshake from the memory stage
//               instruction, alu_result, rf_data1, address, mem_rdata,
//               mem_rvalid             - retiring instruction and operands
//               wb_enable/wb_address/wb_data - register-file write port
//               busy                   - waiting for load data
//               retired_count          - wrapping retired-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_ctrl #(
    parameter int DATA_W       = 20,
    parameter int INSTR_W      = 20,
    parameter int REG_ADDR_W   = 4,
    parameter int R0_HARDWIRED = 0,
    parameter int COUNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_W-1:0]    instruction,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     rf_data1,
    input  logic [REG_ADDR_W-1:0] address,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  wb_enable,
    output logic [REG_ADDR_W-1:0] wb_address,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  busy,
    output logic [COUNT_W-1:0]    retired_count
);

    localparam logic [3:0] c_OP_STORE = 4'b1100;
    localparam logic [3:0] c_OP_CMOV  = 4'b1011;
    localparam logic [3:0] c_OP_LOAD0 = 4'b1111;
    localparam logic [3:0] c_OP_LOAD1 = 4'b1101;
    localparam logic [3:0] c_OP_MOVE  = 4'b1110;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    wb_enable_q, wb_enable_d;
    logic [REG_ADDR_W-1:0]   wb_address_q, wb_address_d;
    logic [DATA_W-1:0]       wb_data_q, wb_data_d;
    logic [COUNT_W-1:0]      count_q, count_d;
    logic [REG_ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic                    pend_we_q, pend_we_d;

    logic [3:0]              w_opcode;
    logic                    w_is_load;
    logic                    w_r0_block;
    logic                    w_dec_we;
    logic [DATA_W-1:0]       w_dec_data;
    logic                    w_accept;
    logic                    w_unused_instr;

    // Only the opcode field matters to this stage.
    assign w_unused_instr = ^instruction[INSTR_W-5:0];

    assign in_ready      = reset && (state_q == IDLE);
    assign busy          = (state_q == WAIT_MEM);
    assign w_accept      = in_valid && in_ready;
    assign wb_enable     = wb_enable_q;
    assign wb_address    = wb_address_q;
    assign wb_data       = wb_data_q;
    assign retired_count = count_q;

    // Opcode decode: write-back source and unqualified write enable.
    always_comb begin
        w_opcode   = instruction[INSTR_W-1 -: 4];
        w_is_load  = (w_opcode == c_OP_LOAD0) || (w_opcode == c_OP_LOAD1);
        w_r0_block = (R0_HARDWIRED != 0) && (address == '0);
        w_dec_we   = 1'b1;
        w_dec_data = alu_result;
        case (w_opcode)
            c_OP_STORE: w_dec_we = 1'b0;
            c_OP_CMOV: begin
                w_dec_we   = (alu_result == '0);
                w_dec_data = rf_data1;
            end
            c_OP_LOAD0, c_OP_LOAD1: w_dec_data = mem_rdata;
            c_OP_MOVE:  w_dec_data = rf_data1;
            default: ;
        endcase
    end

    // Next-state and retire logic. Address and data outputs only move on a
    // retire; the enable is a single-cycle strobe.
    always_comb begin
        state_d      = state_q;
        wb_enable_d  = 1'b0;
        wb_address_d = wb_address_q;
        wb_data_d    = wb_data_q;
        count_d      = count_q;
        pend_addr_d  = pend_addr_q;
        pend_we_d    = pend_we_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (!w_is_load || mem_rvalid) begin
                        wb_enable_d  = w_dec_we && !w_r0_block;
                        wb_address_d = address;
                        wb_data_d    = w_dec_data;
                        count_d      = count_q + COUNT_W'(1);
                    end else begin
                        // Operand buses move on after accept, so keep what the
                        // deferred write needs.
                        pend_addr_d = address;
                        pend_we_d   = !w_r0_block;
                        state_d     = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    wb_enable_d  = pend_we_q;
                    wb_address_d = pend_addr_q;
                    wb_data_d    = mem_rdata;
                    count_d      = count_q + COUNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            wb_enable_q  <= 1'b0;
            wb_address_q <= '0;
            wb_data_q    <= '0;
            count_q      <= '0;
            pend_addr_q  <= '0;
            pend_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wb_enable_q  <= wb_enable_d;
            wb_address_q <= wb_address_d;
            wb_data_q    <= wb_data_d;
            count_q      <= count_d;
            pend_addr_q  <= pend_addr_d;
            pend_we_q    <= pend_we_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage_ctrl
// Description : Scoreboard bench for wb_stage_ctrl. Two instances share the
//               stimulus: A (R0 writable, 16-bit counter) and B (R0 hardwired,
//               4-bit counter). Expected retires are queued per instance and
//               popped by independent monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage_ctrl;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [19:0] data;
        logic [15:0] cnt;
        bit          chk_data;
    } exp_t;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        in_valid, mem_rvalid;
    logic [19:0] instruction, alu_result, rf_data1, mem_rdata;
    logic [3:0]  address;

    logic        rdy_a, we_a, busy_a, rdy_b, we_b, busy_b;
    logic [3:0]  wa_a, wa_b;
    logic [19:0] wd_a, wd_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   tot_a    = 0;
    int   tot_b    = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [15:0] prev_a = '0;
    logic [3:0]  prev_b = '0;

    always #5 clock = ~clock;

    wb_stage_ctrl #(.DATA_W(20), .INSTR_W(20), .REG_ADDR_W(4),
                    .R0_HARDWIRED(0), .COUNT_W(16)) dut_a (
        .clock(clock), .reset(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .instruction(instruction), .alu_result(alu_result), .rf_data1(rf_data1),
        .address(address), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .wb_enable(we_a), .wb_address(wa_a), .wb_data(wd_a), .busy(busy_a),
        .retired_count(cnt_a));

    wb_stage_ctrl #(.DATA_W(20), .INSTR_W(20), .REG_ADDR_W(4),
                    .R0_HARDWIRED(1), .COUNT_W(4)) dut_b (
        .clock(clock), .reset(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .instruction(instruction), .alu_result(alu_result), .rf_data1(rf_data1),
        .address(address), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .wb_enable(we_b), .wb_address(wa_b), .wb_data(wd_b), .busy(busy_b),
        .retired_count(cnt_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of one retire, straight from the opcode table.
    function automatic exp_t model(input bit r0hw, input logic [3:0] op,
                                   input logic [19:0] alu, input logic [19:0] rf1,
                                   input logic [19:0] md, input logic [3:0] addr,
                                   input int total, input int cw);
        exp_t e;
        e.addr = addr;
        e.chk_data = 1'b1;
        if (op == 4'hC) begin
            e.we = 1'b0; e.data = alu; e.chk_data = 1'b0;
        end else if (op == 4'hB) begin
            e.we = (alu == 20'd0); e.data = rf1;
        end else if (op == 4'hF || op == 4'hD) begin
            e.we = 1'b1; e.data = md;
        end else if (op == 4'hE) begin
            e.we = 1'b1; e.data = rf1;
        end else begin
            e.we = 1'b1; e.data = alu;
        end
        if (r0hw && addr == 4'd0) e.we = 1'b0;
        e.cnt = 16'(total % (1 << cw));
        return e;
    endfunction

    task automatic push(input logic [3:0] op, input logic [19:0] alu, input logic [19:0] rf1,
                        input logic [19:0] md, input logic [3:0] addr);
        tot_a++;
        tot_b++;
        q_a.push_back(model(1'b0, op, alu, rf1, md, addr, tot_a, 16));
        q_b.push_back(model(1'b1, op, alu, rf1, md, addr, tot_b, 4));
    endtask

    task automatic sb_cmp(input string tag, input exp_t e, input logic we,
                          input logic [3:0] wa, input logic [19:0] wd, input logic [15:0] c);
        logic [19:0] d_exp;
        d_exp = e.chk_data ? e.data : wd;
        n_checks++;
        if (we !== e.we || wa !== e.addr || wd !== d_exp || c !== e.cnt) begin
            n_fail++;
            $display("FAIL %s retire: got we=%b addr=%h data=%h cnt=%h expected we=%b addr=%h data=%h cnt=%h",
                     tag, we, wa, wd, c, e.we, e.addr, d_exp, e.cnt);
        end
    endtask

    // Monitors: a retire shows up as a counter step or a write strobe.
    always @(negedge clock) begin
        if (!rst_n) begin
            prev_a = cnt_a;
        end else if (cnt_a !== prev_a || we_a === 1'b1) begin
            prev_a = cnt_a;
            if (q_a.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb_a_unexpected: got retire cnt=%h expected none", cnt_a);
            end else begin
                sb_cmp("sb_a", q_a.pop_front(), we_a, wa_a, wd_a, cnt_a);
            end
        end
    end

    always @(negedge clock) begin
        if (!rst_n) begin
            prev_b = cnt_b;
        end else if (cnt_b !== prev_b || we_b === 1'b1) begin
            prev_b = cnt_b;
            if (q_b.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb_b_unexpected: got retire cnt=%h expected none", cnt_b);
            end else begin
                sb_cmp("sb_b", q_b.pop_front(), we_b, wa_b, wd_b, {12'd0, cnt_b});
            end
        end
    end

    // Issue one instruction; for a waiting load, data arrives after 'delay'
    // busy cycles while an unrelated instruction is held on the input.
    // Returns at 1 time unit after the retiring edge.
    task automatic send(input logic [3:0] op, input logic [19:0] alu, input logic [19:0] rf1,
                        input logic [3:0] addr, input int delay, input logic [19:0] md);
        bit is_load;
        int t;
        is_load     = (op == 4'hF) || (op == 4'hD);
        instruction = {op, 16'($urandom)};
        alu_result  = alu;
        rf_data1    = rf1;
        address     = addr;
        mem_rdata   = (is_load && delay > 0) ? 20'($urandom) : md;
        mem_rvalid  = is_load ? (delay == 0) : 1'($urandom);
        in_valid    = 1'b1;
        t = 0;
        @(negedge clock);
        while (rdy_a !== 1'b1) begin
            t++;
            if (t > 20) begin
                chk("ready_timeout", {31'd0, rdy_a}, 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        if (!is_load || delay == 0) begin
            push(op, alu, rf1, md, addr);
        end else begin
            instruction = {4'h0, 16'($urandom)};
            alu_result  = 20'($urandom);
            address     = ~addr;
            mem_rvalid  = 1'b0;
            for (int i = 0; i < delay; i++) begin
                @(negedge clock);
                chk("wait_busy", {31'd0, busy_a}, 32'd1);
                chk("wait_in_ready", {31'd0, rdy_a}, 32'd0);
                if (i == delay - 1) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = md;
                end
            end
            @(posedge clock);
            #1;
            push(op, alu, rf1, md, addr);
            chk("post_load_ready", {31'd0, rdy_a}, 32'd1);
            chk("post_load_busy", {31'd0, busy_a}, 32'd0);
        end
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            mem_rvalid = 1'($urandom);
            @(posedge clock);
            #1;
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        instruction = 20'd0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        q_a.delete();
        q_b.delete();
        tot_a = 0;
        tot_b = 0;
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op, ad;
        logic [19:0] alu;
        rst_n = 1'b0; in_valid = 1'b1; mem_rvalid = 1'b0;
        instruction = 20'd0; alu_result = 20'd0; rf_data1 = 20'd0;
        address = 4'd0; mem_rdata = 20'd0;

        // Reset state with in_valid held high
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", {31'd0, rdy_a}, 32'd0);
        chk("rst_wb_enable", {30'd0, we_a, we_b}, 32'd0);
        chk("rst_wb_address", {24'd0, wa_a, wa_b}, 32'd0);
        chk("rst_wb_data", {12'd0, wd_a}, 32'd0);
        chk("rst_busy", {30'd0, busy_a, busy_b}, 32'd0);
        chk("rst_count", {12'd0, cnt_a, cnt_b}, 32'd0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;

        send(4'h0, 20'h12345, 20'h0, 4'd3, 0, 20'h0);
        chk("first_we", {31'd0, we_a}, 32'd1);
        chk("first_addr", {28'd0, wa_a}, 32'd3);
        chk("first_data", {12'd0, wd_a}, 32'h12345);
        chk("first_count", {16'd0, cnt_a}, 32'd1);

        // Directed decode cases
        send(4'hB, 20'h0, 20'hABCDE, 4'd5, 0, 20'h0);
        send(4'hB, 20'h1, 20'hABCDE, 4'd6, 0, 20'h0);
        send(4'hC, 20'h11111, 20'h22222, 4'd7, 0, 20'h0);
        send(4'h1, 20'h33333, 20'h0, 4'd0, 0, 20'h0);
        send(4'hE, 20'h44444, 20'h55555, 4'd9, 0, 20'h0);
        send(4'hD, 20'h66666, 20'h0, 4'd10, 0, 20'h77777);
        send(4'hF, 20'h0, 20'h0, 4'd11, 3, 20'h0F0F0);
        chk("load_wait_data", {12'd0, wd_a}, 32'h0F0F0);
        send(4'h2, 20'h88888, 20'h0, 4'd12, 0, 20'h0);
        send(4'hD, 20'h0, 20'h0, 4'd0, 1, 20'h99999);

        // Reset during WAIT_MEM abandons the load
        @(negedge clock);
        instruction = {4'hF, 16'h0}; address = 4'd5; in_valid = 1'b1; mem_rvalid = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        q_a.delete(); q_b.delete(); tot_a = 0; tot_b = 0;
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 20'hFFFFF;
        @(posedge clock);
        #1;
        mem_rvalid = 1'b0;
        @(negedge clock);
        chk("midwait_we", {30'd0, we_a, we_b}, 32'd0);
        chk("midwait_count", {12'd0, cnt_a, cnt_b}, 32'd0);
        chk("midwait_idle", {30'd0, busy_a, rdy_a}, 32'd1);
        @(posedge clock);
        #1;

        // Stream of 17 writes: no bubbles, 4-bit counter wraps to 1
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(4'($urandom_range(0, 10)), 20'($urandom), 20'($urandom),
                 4'($urandom_range(1, 15)), 0, 20'($urandom));
            chk("stream_pulse", {30'd0, we_a, we_b}, 32'd3);
        end
        chk("stream_count_b", {28'd0, cnt_b}, 32'd1);
        chk("stream_count_a", {16'd0, cnt_a}, 32'd17);

        // Randomized traffic
        for (int i = 0; i < 120; i++) begin
            op  = 4'($urandom);
            alu = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom);
            ad  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
            send(op, alu, 20'($urandom), ad, $urandom_range(0, 3), 20'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(3);
        chk("sb_a_drained", q_a.size(), 32'd0);
        chk("sb_b_drained", q_b.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
